// File: rtl/riscv_arb_mux.sv
// rtl/riscv_arb_mux.sv - registered N-channel valid/ready mux with fixed-select or round-robin arbitration
module riscv_arb_mux #(
  parameter int N_MUX_IN = 2,
  parameter int DW       = 32,
  localparam int SW      = (N_MUX_IN > 1) ? $clog2(N_MUX_IN) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [N_MUX_IN*DW-1:0] i_mux_concat_data,
  input  logic [N_MUX_IN-1:0]    i_mux_valid,
  output logic [N_MUX_IN-1:0]    o_mux_ready,
  input  logic                   i_mux_mode,
  input  logic [SW-1:0]          i_mux_sel,
  output logic [DW-1:0]          o_mux_data,
  output logic                   o_mux_valid,
  input  logic                   i_mux_ready,
  output logic [SW-1:0]          o_mux_grant
);

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] cand;
  logic          cand_found;
  logic          load_en;
  logic          take_in;
  int            idx;

  assign load_en = !o_mux_valid || i_mux_ready;

  // RR search starts just after the last granted channel and wraps back to it
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    idx        = 0;
    if (!i_mux_mode) begin
      if (int'(i_mux_sel) < N_MUX_IN) begin
        cand       = i_mux_sel;
        cand_found = 1'b1;
      end
    end else begin
      for (int i = 1; i <= N_MUX_IN; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= N_MUX_IN) idx = idx - N_MUX_IN;
        if (!cand_found && i_mux_valid[SW'(idx)]) begin
          cand       = SW'(idx);
          cand_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_mux_ready = '0;
    for (int k = 0; k < N_MUX_IN; k++) begin
      o_mux_ready[k] = i_rstn && load_en && cand_found && (cand == SW'(k));
    end
  end

  assign take_in = cand_found && load_en && i_mux_valid[cand];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_mux_valid <= 1'b0;
      o_mux_data  <= '0;
      o_mux_grant <= '0;
      rr_ptr      <= SW'(N_MUX_IN - 1);
    end else if (take_in) begin
      o_mux_valid <= 1'b1;
      o_mux_data  <= i_mux_concat_data[int'(cand)*DW +: DW];
      o_mux_grant <= cand;
      if (i_mux_mode) rr_ptr <= cand;
    end else if (o_mux_valid && i_mux_ready) begin
      o_mux_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_arb_mux.sv
// tb/tb_riscv_arb_mux.sv - scoreboard bench for riscv_arb_mux with N=4 and N=3 instances
module tb_riscv_arb_mux;

  logic         clk;
  logic         rstn;

  logic [127:0] d4;
  logic [3:0]   v4, r4;
  logic         mode4, ov4, ir4;
  logic [1:0]   sel4, g4;
  logic [31:0]  od4;

  logic [95:0]  d3;
  logic [2:0]   v3, r3;
  logic         mode3, ov3, ir3;
  logic [1:0]   sel3, g3;
  logic [31:0]  od3;

  logic [33:0]  q4[$];
  logic [33:0]  q3[$];
  logic [33:0]  e;

  int checks = 0;
  int errors = 0;

  riscv_arb_mux #(.N_MUX_IN(4), .DW(32)) u4 (
    .i_clk(clk), .i_rstn(rstn), .i_mux_concat_data(d4), .i_mux_valid(v4),
    .o_mux_ready(r4), .i_mux_mode(mode4), .i_mux_sel(sel4), .o_mux_data(od4),
    .o_mux_valid(ov4), .i_mux_ready(ir4), .o_mux_grant(g4)
  );

  riscv_arb_mux #(.N_MUX_IN(3), .DW(32)) u3 (
    .i_clk(clk), .i_rstn(rstn), .i_mux_concat_data(d3), .i_mux_valid(v3),
    .o_mux_ready(r3), .i_mux_mode(mode3), .i_mux_sel(sel3), .o_mux_data(od3),
    .o_mux_valid(ov3), .i_mux_ready(ir3), .o_mux_grant(g3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: check ready, push expected on accept, pop/compare on drain
  task automatic cyc(input logic [3:0] er4, input logic [2:0] er3);
    #4;
    chk("ready4", r4, er4);
    chk("ready3", r3, er3);
    if (ov4 && ir4) begin
      if (q4.size() == 0) chk("out4_unexpected", 1, 0);
      else begin
        e = q4.pop_front();
        chk("out4_grant", g4, e[33:32]);
        chk("out4_data", od4, e[31:0]);
      end
    end
    if (ov3 && ir3) begin
      if (q3.size() == 0) chk("out3_unexpected", 1, 0);
      else begin
        e = q3.pop_front();
        chk("out3_grant", g3, e[33:32]);
        chk("out3_data", od3, e[31:0]);
      end
    end
    for (int k = 0; k < 4; k++)
      if (er4[k] && v4[k]) q4.push_back({2'(k), 32'hCAFE0000 + 32'(k)});
    for (int k = 0; k < 3; k++)
      if (er3[k] && v3[k]) q3.push_back({2'(k), 32'hBEEF0000 + 32'(k)});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) d4[k*32 +: 32] = 32'hCAFE0000 + 32'(k);
    for (int k = 0; k < 3; k++) d3[k*32 +: 32] = 32'hBEEF0000 + 32'(k);
    rstn = 1'b0;
    v4 = 4'hF; v3 = 3'h7;
    mode4 = 1'b0; sel4 = 2'd0; ir4 = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; ir3 = 1'b1;
    repeat (2) @(negedge clk);

    // reset with every channel offering data
    #1;
    chk("rst_valid4", ov4, 0);
    chk("rst_data4", od4, 0);
    chk("rst_grant4", g4, 0);
    chk("rst_ready4", r4, 0);
    chk("rst_valid3", ov3, 0);
    chk("rst_data3", od3, 0);
    chk("rst_ready3", r3, 0);
    @(negedge clk);
    v4 = 4'h0; v3 = 3'h0; mode3 = 1'b1;
    rstn = 1'b1;

    // fixed select, sel=2
    mode4 = 1'b0; sel4 = 2'd2; v4 = 4'hF;
    cyc(4'b0100, 3'b000);
    v4 = 4'h0;
    chk("fix_valid4", ov4, 1);
    cyc(4'b0100, 3'b000);
    chk("fix_drained4", ov4, 0);
    mode4 = 1'b1;

    // round robin N=3, all valid, no bubbles
    v3 = 3'h7;
    cyc(4'b0000, 3'b001);
    for (int n = 0; n < 5; n++) begin
      chk("rr3_nobubble", ov3, 1);
      cyc(4'b0000, 3'(1 << ((n + 1) % 3)));
    end
    v3 = 3'h0;
    cyc(4'b0000, 3'b000);
    chk("rr3_drained", ov3, 0);

    // round robin N=4 over sparse valids
    v4 = 4'b0010;
    cyc(4'b0010, 3'b000);
    v4 = 4'b1010;
    cyc(4'b1000, 3'b000);
    cyc(4'b0010, 3'b000);
    cyc(4'b1000, 3'b000);
    v4 = 4'h0;
    cyc(4'b0000, 3'b000);
    chk("rr4_drained", ov4, 0);

    // back-pressure hold then drain+reload in one cycle
    v4 = 4'b1010;
    cyc(4'b0010, 3'b000);
    ir4 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc(4'b0000, 3'b000);
      chk("bp_valid", ov4, 1);
      chk("bp_grant", g4, 1);
      chk("bp_data", od4, 32'hCAFE0001);
    end
    ir4 = 1'b1;
    cyc(4'b1000, 3'b000);
    v4 = 4'h0;
    chk("bp_reload_valid", ov4, 1);
    cyc(4'b0000, 3'b000);
    chk("bp_drained", ov4, 0);

    // fixed select out of range on N=3
    mode3 = 1'b0; sel3 = 2'd1; v3 = 3'h7;
    cyc(4'b0000, 3'b010);
    sel3 = 2'd3;
    cyc(4'b0000, 3'b000);
    chk("oor_valid3", ov3, 0);
    cyc(4'b0000, 3'b000);

    // reset while the output register is full
    sel3 = 2'd0; v3 = 3'b001; ir3 = 1'b0;
    cyc(4'b0000, 3'b001);
    chk("midrst_loaded", ov3, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_valid3", ov3, 0);
    chk("midrst_data3", od3, 0);
    chk("midrst_grant3", g3, 0);
    chk("midrst_ready3", r3, 0);
    q3.delete();

    chk("q4_empty", q4.size(), 0);
    chk("q3_empty", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
